// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO result registers.
// Optional feature macro: MULDIV_FAST_MULT_EN (single-cycle MULT/MULTU).
module hilo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic             Abort,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI_out,
  output logic [WIDTH-1:0] LO_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               dz_q, dz_d;
  logic               done_q, done_d;

  logic               signed_op, sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     add_sum, shifted, diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    rem_d    = rem_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    done_d   = 1'b0;

    signed_op = ~Op[0];
    sign_a    = signed_op & OpA[WIDTH-1];
    sign_b    = signed_op & OpB[WIDTH-1];
    mag_a     = sign_a ? -OpA : OpA;
    mag_b     = sign_b ? -OpB : OpB;

    // Multiply step: conditional add into the upper half, then shift right.
    add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    // Divide step: restoring division, quotient bits shift into acc low half.
    shifted = {rem_q, acc_q[WIDTH-1]};
    diff    = shifted - {1'b0, opb_q};

    prod_fix = neg_q ? -acc_q : acc_q;
    quot_fix = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = rneg_q ? -rem_q : rem_q;

    case (state_q)
      S_IDLE: begin
        if (Start && !Abort) begin
          case (Op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              is_div_d = Op[1];
              neg_d    = sign_a ^ sign_b;
              rneg_d   = sign_a;
              dz_d     = Op[1] && (OpB == '0);
              cnt_d    = CNT_W'(WIDTH);
              rem_d    = '0;
              state_d  = S_RUN;
              if (Op[1]) begin
                acc_d = {{WIDTH{1'b0}}, mag_a};
                opb_d = mag_b;
              end else begin
`ifdef MULDIV_FAST_MULT_EN
                acc_d   = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
                opb_d   = mag_a;
                state_d = S_FIX;
`else
                acc_d = {{WIDTH{1'b0}}, mag_b};
                opb_d = mag_a;
`endif
              end
            end
            3'd4: begin
              hi_d   = OpA;
              done_d = 1'b1;
            end
            3'd5: begin
              lo_d   = OpA;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (Abort) begin
          state_d = S_IDLE;
        end else begin
          if (is_div_q) begin
            if (!diff[WIDTH]) begin
              rem_d = diff[WIDTH-1:0];
              acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b1};
            end else begin
              rem_d = shifted[WIDTH-1:0];
              acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_d = {add_sum, acc_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!Abort) begin
          done_d = 1'b1;
          if (is_div_q) begin
            lo_d = dz_q ? '1 : quot_fix;
            hi_d = rem_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      rem_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      rem_q    <= rem_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
    end
  end

  assign Busy   = (state_q != S_IDLE);
  assign Done   = done_q;
  assign HI_out = hi_q;
  assign LO_out = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed corner cases plus random ops
// against an arithmetic reference model of HI/LO.
module tb_hilo_muldiv_unit;

  localparam int W = 32;
`ifdef MULDIV_FAST_MULT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic         Clk = 1'b0;
  logic         Rst = 1'b0;
  logic         Start = 1'b0;
  logic [2:0]   Op = '0;
  logic [W-1:0] OpA = '0;
  logic [W-1:0] OpB = '0;
  logic         Abort = 1'b0;
  logic         Busy, Done;
  logic [W-1:0] HI_out, LO_out;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  hilo_muldiv_unit #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .OpA(OpA), .OpB(OpB),
    .Abort(Abort), .Busy(Busy), .Done(Done), .HI_out(HI_out), .LO_out(LO_out)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: MIPS HI/LO semantics in plain 64-bit arithmetic.
  task automatic model_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint       sa, sb;
    logic [63:0]  p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin p = 64'(sa * sb); {m_hi, m_lo} = p; end
      3'd1: begin p = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = p; end
      3'd2: begin
        if (b == 0) begin m_lo = '1; m_hi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin m_lo = a; m_hi = '0; end
        else begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
      end
      3'd3: begin
        if (b == 0) begin m_lo = '1; m_hi = a; end
        else begin m_lo = a / b; m_hi = a % b; end
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge Clk);
    Start = 1'b1; Op = op; OpA = a; OpB = b;
    @(posedge Clk);
    #1 Start = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [2:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    int lat, exp_lat;
    model_op(op, a, b);
    issue(op, a, b);
    if (op > 3'd5) begin
      check({tag, "_nop_done"}, 64'(Done), 64'd0);
      check({tag, "_nop_busy"}, 64'(Busy), 64'd0);
    end else begin
      exp_lat = (op >= 3'd4) ? 0 : ((FAST && op < 3'd2) ? 1 : W + 1);
      if (op < 3'd4) check({tag, "_busy"}, 64'(Busy), 64'd1);
      lat = Done ? 0 : 999;
      if (!Done) begin
        for (int k = 1; k <= 200; k++) begin
          @(posedge Clk); #1;
          if (Done) begin lat = k; break; end
        end
      end
      check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      check({tag, "_busy_end"}, 64'(Busy), 64'd0);
      @(posedge Clk); #1;
      check({tag, "_pulse"}, 64'(Done), 64'd0);
    end
    check({tag, "_hi"}, 64'(HI_out), 64'(m_hi));
    check({tag, "_lo"}, 64'(LO_out), 64'(m_lo));
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return W'($urandom_range(0, 20));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #2;
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_done", 64'(Done), 64'd0);
    check("rst_hi", 64'(HI_out), 64'd0);
    check("rst_lo", 64'(LO_out), 64'd0);
    @(negedge Clk); Rst = 1'b1;

    do_op("mult_neg", 3'd0, 32'hFFFF_FFFF, 32'h0000_0002);
    do_op("multu", 3'd1, 32'hFFFF_FFFF, 32'h0000_0002);
    do_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'h0000_0002);
    do_op("divu", 3'd3, 32'd7, 32'd2);
    do_op("divu_z", 3'd3, 32'd7, 32'd0);
    do_op("div_z_neg", 3'd2, 32'hFFFF_FFF9, 32'd0);
    do_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("nop6", 3'd6, 32'h1111, 32'h2222);
    do_op("mthi", 3'd4, 32'h1234, 32'h0);
    do_op("mtlo", 3'd5, 32'h5678, 32'h0);

    // Abort mid-divide; a Start issued while busy must also be dropped.
    issue(3'd2, 32'd1000, 32'd7);
    for (int c = 1; c < 10; c++) begin
      @(negedge Clk);
      Start = (c == 3); Op = 3'd4; OpA = 32'hDEAD;
      @(posedge Clk); #1;
      check("abort_busy_run", 64'(Busy), 64'd1);
      check("abort_nodone_run", 64'(Done), 64'd0);
    end
    @(negedge Clk); Start = 1'b0; Abort = 1'b1;
    @(posedge Clk); #1;
    Abort = 1'b0;
    check("abort_busy", 64'(Busy), 64'd0);
    check("abort_done", 64'(Done), 64'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge Clk); #1;
      check("abort_nodone", 64'(Done), 64'd0);
    end
    check("abort_hi", 64'(HI_out), 64'h1234);
    check("abort_lo", 64'(LO_out), 64'h5678);

    // Abort together with Start in IDLE drops the Start.
    @(negedge Clk); Start = 1'b1; Abort = 1'b1; Op = 3'd4; OpA = 32'hBEEF;
    @(posedge Clk); #1; Start = 1'b0; Abort = 1'b0;
    check("abst_done", 64'(Done), 64'd0);
    check("abst_busy", 64'(Busy), 64'd0);
    check("abst_hi", 64'(HI_out), 64'h1234);

    // Asynchronous reset during a multiply.
    do_op("mult_pre", 3'd1, 32'h0001_0000, 32'h0003_0000);
    issue(3'd0, 32'd123, 32'd456);
    for (int c = 1; c < 15; c++) @(posedge Clk);
    #2 Rst = 1'b0;
    #1;
    check("mrst_busy", 64'(Busy), 64'd0);
    check("mrst_done", 64'(Done), 64'd0);
    check("mrst_hi", 64'(HI_out), 64'd0);
    check("mrst_lo", 64'(LO_out), 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge Clk); Rst = 1'b1;
    do_op("mult_3x5", 3'd0, 32'd3, 32'd5);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] op;
      op = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
      do_op($sformatf("rnd%0d_op%0d", i, op), op, rnd_operand(), rnd_operand());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
